// File: rtl/pacman_mover.sv
// Pac-Man position/direction sequencer: synchronises the frame pulse, prescales it into
// movement steps, buffers the requested turn and resolves each step against the maze.
module pacman_mover #(
    parameter int START_X     = 222,
    parameter int START_Y     = 336,
    parameter int STEP_DIV    = 1,
    parameter int TUNNEL_Y    = 228,
    parameter int TUNNEL_X_LO = 66,
    parameter int TUNNEL_X_HI = 390
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic [3:0] availible_dir,
    input  logic       freeze,
    output logic [9:0] pacmanPosX,
    output logic [9:0] pacmanPosY,
    output logic [1:0] pac_dir,
    output logic       moving,
    output logic [1:0] anim_frame
);
    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_UP    = 2'd1,
        DIR_RIGHT = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_e;

    localparam logic [9:0] START_X_V = 10'(START_X);
    localparam logic [9:0] START_Y_V = 10'(START_Y);
    localparam logic [9:0] TUN_Y_V   = 10'(TUNNEL_Y);
    localparam logic [9:0] TUN_LO_V  = 10'(TUNNEL_X_LO);
    localparam logic [9:0] TUN_HI_V  = 10'(TUNNEL_X_HI);
    localparam logic [3:0] DIV_LAST  = 4'(STEP_DIV - 1);

    logic       sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, tick_q, tick_d;
    logic [3:0] presc_q, presc_d;
    dir_e       desired_q, desired_d, dir_q, dir_d, move_dir;
    logic [9:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic       moving_q, moving_d;
    logic [1:0] anim_q, anim_d;
    logic       step, do_move, at_tunnel_l, at_tunnel_r;

    assign at_tunnel_l = (pos_y_q == TUN_Y_V) && (dir_q == DIR_LEFT)  && (pos_x_q == TUN_LO_V);
    assign at_tunnel_r = (pos_y_q == TUN_Y_V) && (dir_q == DIR_RIGHT) && (pos_x_q == TUN_HI_V);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        sync1_d   = frame_clk;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        tick_d    = sync2_q & ~prev_q;

        desired_d = desired_q;
        case (keycode)
            8'h04:   desired_d = DIR_LEFT;
            8'h1A:   desired_d = DIR_UP;
            8'h07:   desired_d = DIR_RIGHT;
            8'h16:   desired_d = DIR_DOWN;
            default: desired_d = desired_q;
        endcase

        presc_d = presc_q;
        step    = 1'b0;
        if (tick_q && !freeze) begin
            if (presc_q == DIV_LAST) begin
                presc_d = 4'd0;
                step    = 1'b1;
            end else begin
                presc_d = presc_q + 4'd1;
            end
        end

        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        dir_d    = dir_q;
        moving_d = moving_q;
        anim_d   = anim_q;
        move_dir = dir_q;
        do_move  = 1'b0;

        if (step) begin
            if (at_tunnel_l || at_tunnel_r) begin
                pos_x_d  = at_tunnel_l ? TUN_HI_V : TUN_LO_V;
                moving_d = 1'b1;
                anim_d   = anim_q + 2'd1;
            end else if (availible_dir[desired_q]) begin
                dir_d    = desired_q;
                move_dir = desired_q;
                do_move  = 1'b1;
            end else if (availible_dir[dir_q]) begin
                do_move  = 1'b1;
            end else begin
                moving_d = 1'b0;
            end
        end

        if (do_move) begin
            moving_d = 1'b1;
            anim_d   = anim_q + 2'd1;
            case (move_dir)
                DIR_LEFT:  pos_x_d = pos_x_q - 10'd1;
                DIR_UP:    pos_y_d = pos_y_q - 10'd1;
                DIR_RIGHT: pos_x_d = pos_x_q + 10'd1;
                default:   pos_y_d = pos_y_q + 10'd1;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            tick_q    <= 1'b0;
            presc_q   <= 4'd0;
            desired_q <= DIR_LEFT;
            dir_q     <= DIR_LEFT;
            pos_x_q   <= START_X_V;
            pos_y_q   <= START_Y_V;
            moving_q  <= 1'b0;
            anim_q    <= 2'd0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            tick_q    <= tick_d;
            presc_q   <= presc_d;
            desired_q <= desired_d;
            dir_q     <= dir_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            moving_q  <= moving_d;
            anim_q    <= anim_d;
        end
    end

    assign pacmanPosX = pos_x_q;
    assign pacmanPosY = pos_y_q;
    assign pac_dir    = dir_q;
    assign moving     = moving_q;
    assign anim_frame = anim_q;
endmodule

// File: tb/tb_pacman_mover.sv
// Directed bench for pacman_mover: a vector table for the default instance plus
// hand sequences for reset, tunnel wrap and the prescaler/freeze interaction.
module tb_pacman_mover;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic frame_clk = 1'b0;

    logic [7:0] d_key = 8'h00, t_key = 8'h00, s_key = 8'h00;
    logic [3:0] d_avail = 4'b0000, t_avail = 4'b0000, s_avail = 4'b0000;
    logic       d_frz = 1'b0, t_frz = 1'b0, s_frz = 1'b0;

    logic [9:0] d_x, d_y, t_x, t_y, s_x, s_y;
    logic [1:0] d_dir, t_dir, s_dir, d_anim, t_anim, s_anim;
    logic       d_mov, t_mov, s_mov;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pacman_mover u_dut (
        .Clk(clk), .Reset(rst), .frame_clk(frame_clk), .keycode(d_key),
        .availible_dir(d_avail), .freeze(d_frz), .pacmanPosX(d_x), .pacmanPosY(d_y),
        .pac_dir(d_dir), .moving(d_mov), .anim_frame(d_anim)
    );

    pacman_mover #(.START_X(67), .START_Y(228)) u_tun (
        .Clk(clk), .Reset(rst), .frame_clk(frame_clk), .keycode(t_key),
        .availible_dir(t_avail), .freeze(t_frz), .pacmanPosX(t_x), .pacmanPosY(t_y),
        .pac_dir(t_dir), .moving(t_mov), .anim_frame(t_anim)
    );

    pacman_mover #(.STEP_DIV(3)) u_slow (
        .Clk(clk), .Reset(rst), .frame_clk(frame_clk), .keycode(s_key),
        .availible_dir(s_avail), .freeze(s_frz), .pacmanPosX(s_x), .pacmanPosY(s_y),
        .pac_dir(s_dir), .moving(s_mov), .anim_frame(s_anim)
    );

    typedef struct {
        logic [7:0] key;
        logic [3:0] avail;
        logic       frz;
        int         pulses;
        int         ex, ey, edir, emov, eanim;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic do_reset();
        frame_clk = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // One frame pulse; the step lands 4 edges after the rise, well inside the window.
    task automatic pulse();
        @(negedge clk);
        frame_clk = 1'b1;
        repeat (5) @(negedge clk);
        frame_clk = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{8'h00, 4'b0101, 1'b0, 3, 219, 336, 0, 1, 3};
        vecs[1]  = '{8'h1A, 4'b0101, 1'b0, 1, 218, 336, 0, 1, 0};
        vecs[2]  = '{8'h00, 4'b0101, 1'b0, 1, 217, 336, 0, 1, 1};
        vecs[3]  = '{8'h00, 4'b0111, 1'b0, 1, 217, 335, 1, 1, 2};
        vecs[4]  = '{8'h04, 4'b0101, 1'b0, 1, 216, 335, 0, 1, 3};
        vecs[5]  = '{8'h00, 4'b0000, 1'b0, 5, 216, 335, 0, 0, 3};
        vecs[6]  = '{8'h00, 4'b0001, 1'b0, 1, 215, 335, 0, 1, 0};
        vecs[7]  = '{8'h07, 4'b0001, 1'b0, 1, 214, 335, 0, 1, 1};
        vecs[8]  = '{8'h00, 4'b0100, 1'b0, 1, 215, 335, 2, 1, 2};
        vecs[9]  = '{8'h16, 4'b1000, 1'b0, 1, 215, 336, 3, 1, 3};
        vecs[10] = '{8'h55, 4'b0001, 1'b0, 1, 215, 336, 3, 0, 3};
        vecs[11] = '{8'h00, 4'b1111, 1'b1, 2, 215, 336, 3, 0, 3};
        vecs[12] = '{8'h00, 4'b1000, 1'b0, 1, 215, 337, 3, 1, 0};

        // Reset asserted in the middle of a pending step
        do_reset();
        d_avail = 4'b0101;
        pulse();
        check("pre_reset_x", d_x, 221);
        @(negedge clk);
        frame_clk = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_x", d_x, 222);
        check("rst_y", d_y, 336);
        check("rst_dir", d_dir, 0);
        check("rst_mov", d_mov, 0);
        check("rst_anim", d_anim, 0);
        frame_clk = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_x", d_x, 222);

        // Table-driven vectors on the default instance
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            d_key   = vecs[i].key;
            d_avail = vecs[i].avail;
            d_frz   = vecs[i].frz;
            for (int p = 0; p < vecs[i].pulses; p++) pulse();
            check($sformatf("v%0d_x", i), d_x, vecs[i].ex);
            check($sformatf("v%0d_y", i), d_y, vecs[i].ey);
            check($sformatf("v%0d_dir", i), d_dir, vecs[i].edir);
            check($sformatf("v%0d_mov", i), d_mov, vecs[i].emov);
            check($sformatf("v%0d_anim", i), d_anim, vecs[i].eanim);
        end
        d_key = 8'h00;
        d_frz = 1'b0;

        // Tunnel wrap in both directions
        do_reset();
        check("tun_rst_x", t_x, 67);
        check("tun_rst_y", t_y, 228);
        t_avail = 4'b0001;
        pulse();
        check("tun_s1_x", t_x, 66);
        pulse();
        check("tun_wrap_x", t_x, 390);
        check("tun_wrap_mov", t_mov, 1);
        check("tun_wrap_anim", t_anim, 2);
        pulse();
        check("tun_back_x", t_x, 389);
        t_key = 8'h07;
        t_avail = 4'b0100;
        pulse();
        check("tun_right_x", t_x, 390);
        check("tun_right_dir", t_dir, 2);
        t_key = 8'h00;
        t_avail = 4'b0000;
        pulse();
        check("tun_wrap2_x", t_x, 66);
        check("tun_wrap2_mov", t_mov, 1);
        check("tun_wrap2_anim", t_anim, 1);
        check("tun_wrap2_y", t_y, 228);

        // Prescaler with freeze on the STEP_DIV=3 instance
        do_reset();
        s_avail = 4'b0001;
        s_frz = 1'b1;
        for (int p = 0; p < 6; p++) pulse();
        check("slow_frz_x", s_x, 222);
        check("slow_frz_mov", s_mov, 0);
        s_frz = 1'b0;
        pulse();
        check("slow_p1_x", s_x, 222);
        pulse();
        check("slow_p2_x", s_x, 222);
        pulse();
        check("slow_p3_x", s_x, 221);
        check("slow_p3_anim", s_anim, 1);
        pulse();
        pulse();
        check("slow_p5_x", s_x, 221);
        pulse();
        check("slow_p6_x", s_x, 220);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pacman_mover.md
Name: pacman_mover

Overview:
- Owns Pac-Man's pixel position registers (pacmanPosX/pacmanPosY) and sequences movement once per step.
- Feeds the maze-legality checker and consumes its 4-bit availible_dir result.
- Buffers the player's requested direction (USB keycode) until the maze allows the turn.
- Handles the row-14 side tunnel wrap.
- Outputs drive the sprite renderer and the ghost/pellet logic.

Parameters:
- START_X, 222, reset X pixel (tile col 13, aligned: X%12==6).
- START_Y, 336, reset Y pixel (tile row 23, aligned: Y%12==0).
- STEP_DIV, 1, frame ticks per 1-pixel step (1..15).
- TUNNEL_Y, 228, Y pixel of tunnel row (row 14).
- TUNNEL_X_LO, 66, X of leftmost tunnel tile (col 0).
- TUNNEL_X_HI, 390, X of rightmost tunnel tile (col 27).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  vertical-sync-rate pulse, asynchronous to Clk.
- keycode  in  8  current USB HID key: 0x04=A left, 0x1A=W up, 0x07=D right, 0x16=S down; all other values ignored.
- availible_dir  in  4  legal moves from the current position. Bit 0 = left, 1 = up, 2 = right, 3 = down.
- freeze  in  1  hold all motion (death/level-clear sequences).
- pacmanPosX  out  10  current X pixel.
- pacmanPosY  out  10  current Y pixel.
- pac_dir  out  2  facing direction; same encoding as availible_dir bit index.
- moving  out  1  1 if the last step moved.
- anim_frame  out  2  mouth animation frame.

Behaviour:
- Reset (async, any time, including mid-step):
  - pacmanPosX=START_X, pacmanPosY=START_Y.
  - pac_dir=0 (left), desired_dir=0, moving=0, anim_frame=0.
  - Prescaler=0 and sync flops=0. No tick fires in the first 2 cycles after release.
- Tick generation:
  - frame_clk passes through a 2-flop synchronizer, then rising-edge detection.
  - One tick = one Clk cycle, issued 3 cycles after the rising edge.
- Prescaler:
  - Counts ticks 0..STEP_DIV-1.
  - The tick where count==STEP_DIV-1 is a step; the counter returns to 0.
  - freeze=1 holds the prescaler, and a step occurring while freeze=1 has no effect on position, pac_dir or anim_frame.
- Desired-direction buffer:
  - Updated every Clk cycle when keycode is one of the four valid codes.
  - Otherwise holds; releasing the key does NOT clear it.
- Step resolution, priority order, evaluated in the single step cycle:
  1. Tunnel: pacmanPosY==TUNNEL_Y, pac_dir==0, pacmanPosX==TUNNEL_X_LO → X=TUNNEL_X_HI, moving=1, regardless of availible_dir. Mirror case: pac_dir==2 at TUNNEL_X_HI → X=TUNNEL_X_LO.
  2. availible_dir[desired_dir]==1 → pac_dir=desired_dir, then move 1 px in that direction.
  3. Else availible_dir[pac_dir]==1 → move 1 px in pac_dir.
  4. Else no move; moving=0; pac_dir unchanged.
- Move arithmetic:
  - left: X-1; up: Y-1; right: X+1; down: Y+1.
  - 10-bit; no saturation needed, because availible_dir never permits leaving the maze.
- availible_dir timing:
  - Combinational from the registered position.
  - Sampled only in the step cycle. It is stable because steps are ≥1 frame apart.
- anim_frame: increments modulo 4 on every step that moves (including a tunnel wrap); holds otherwise.
- Outputs are registered and change only on a step cycle or at reset.
- Simultaneous events:
  - keycode changes in the step cycle: the step uses the old desired_dir.
  - freeze rising in the step cycle: the step is suppressed.

Test Plan:
1. Assert Reset mid-motion at an arbitrary cycle → outputs immediately read X=222, Y=336, pac_dir=0, moving=0, anim_frame=0.
2. Default params, availible_dir=4'b0101, no key, 3 frame_clk pulses → X=219, Y=336, moving=1, anim_frame=3.
3. Hold availible_dir=0101, press W (0x1A) then release, 2 steps → X decrements twice, pac_dir=0. Then availible_dir=0111, 1 step → Y=335, pac_dir=1, X unchanged.
4. pac_dir=0, availible_dir=0000, 5 steps → X/Y unchanged, moving=0, anim_frame frozen. Then availible_dir=0001 → next step X-1, moving=1.
5. Instance with START_X=67, START_Y=228, availible_dir=0001 → step 1 X=66; step 2 X=390 (wrap), moving=1. Then D (0x07) with availible_dir=0100, positioned at 390 → next step X=66.
6. STEP_DIV=3, freeze=1 over 6 pulses → no change. Release freeze → the position moves on every 3rd pulse only.
